k2red_pipe: RTL

- Parametrised, fully pipelined K^2-RED modular reducer for primes q = k·2^m + 1, where k = 2^k1 ± 2^k2.
- Computes C = (k^2 · A) mod q, fully reduced to [0, q), using shift/add only (no multipliers).
- Successor to the fixed-width 64-bit shift reducer. Adds a width parameter, runtime selection of the k sign, per-beat configuration, and a valid/ready streaming interface with backpressure.
- Sits behind the NTT butterfly multiplier and feeds the butterfly add/sub stage.

---
 rtl/k2red_if.sv | 29 ++
 rtl/k2red_pipe.sv | 109 ++++++++++
 2 files changed

// File: rtl/k2red_if.sv
// Stream interface for the K^2-RED reducer: operand and configuration in, reduced result out.
// A beat moves when valid and ready are both high on a rising edge; the source holds its payload
// until then, and a sink may raise ready before valid arrives.
interface k2red_if #(
  parameter int N  = 64,
  parameter int KW = 7
);
  logic            in_valid;
  logic            in_ready;
  logic [2*N-1:0]  A;
  logic [N-1:0]    Q;
  logic [KW-1:0]   k1;
  logic [KW-1:0]   k2;
  logic            ksign;
  logic [KW-1:0]   m;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    C2;

  modport master (
    output in_valid, A, Q, k1, k2, ksign, m, out_ready,
    input  in_ready, out_valid, C2
  );

  modport slave (
    input  in_valid, A, Q, k1, k2, ksign, m, out_ready,
    output in_ready, out_valid, C2
  );
endinterface

// File: rtl/k2red_pipe.sv
// Pipelined K^2-RED reducer: C2 = (k^2 * A) mod q for q = k*2^m + 1, k = 2^k1 +/- 2^k2.
// Stages: capture, K-RED, K-RED, correction candidates, candidate select into the output register.
module k2red_pipe #(
  parameter int N  = 64,
  parameter int KW = 7
) (
  input logic   clk,
  input logic   rst,
  k2red_if.slave bus
);
  localparam int W = 2 * N + 2;
  typedef logic signed [W-1:0] wide_t;

  // k*x as two shifted copies of x, added or subtracted by the sign of the second term.
  function automatic wide_t kmul(wide_t x, logic [KW-1:0] e1, logic [KW-1:0] e2, logic ks);
    wide_t p;
    wide_t r;
    p = x <<< e1;
    r = x <<< e2;
    return ks ? (p + r) : (p - r);
  endfunction

  // One K-RED step: k*(c mod 2^m) - floor(c / 2^m), congruent to k*c mod q.
  function automatic wide_t kred(wide_t c, logic [KW-1:0] sh, logic [KW-1:0] e1,
                                 logic [KW-1:0] e2, logic ks);
    wide_t mask;
    wide_t lo;
    wide_t hi;
    mask = ~({W{1'b1}} << sh);
    lo   = c & mask;
    hi   = c >>> sh;
    return kmul(lo, e1, e2, ks) - hi;
  endfunction

  logic adv;

  logic           s0_v, s1_v, s2_v, s3_v, out_v;
  logic [2*N-1:0] s0_a;
  logic [N-1:0]   s0_q, s1_q, s2_q, s3_q;
  logic [KW-1:0]  s0_k1, s0_k2, s0_m, s1_k1, s1_k2, s1_m;
  logic           s0_ks, s1_ks;
  wide_t          s1_c, s2_c;
  wide_t          s3_cand [4];
  logic [N-1:0]   c2_r;
  logic [N-1:0]   sel;
  wide_t          q3x;
  wide_t          q2x;

  assign adv           = !out_v | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_v;
  assign bus.C2        = c2_r;
  assign q2x           = wide_t'({{(W-N){1'b0}}, s2_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v  <= 1'b0;
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      s3_v  <= 1'b0;
      out_v <= 1'b0;
      c2_r  <= '0;
    end else if (adv) begin
      s0_v  <= bus.in_valid;
      s1_v  <= s0_v;
      s2_v  <= s1_v;
      s3_v  <= s2_v;
      out_v <= s3_v;
      if (s3_v) c2_r <= sel;
    end
  end

  // Configuration rides alongside each beat, so back-to-back beats may use different moduli.
  always_ff @(posedge clk) begin
    if (adv) begin
      s0_a  <= bus.A;
      s0_q  <= bus.Q;
      s0_k1 <= bus.k1;
      s0_k2 <= bus.k2;
      s0_ks <= bus.ksign;
      s0_m  <= bus.m;

      s1_c  <= kred(wide_t'({2'b00, s0_a}), s0_m, s0_k1, s0_k2, s0_ks);
      s1_q  <= s0_q;
      s1_k1 <= s0_k1;
      s1_k2 <= s0_k2;
      s1_ks <= s0_ks;
      s1_m  <= s0_m;

      s2_c  <= kred(s1_c, s1_m, s1_k1, s1_k2, s1_ks);
      s2_q  <= s1_q;

      s3_cand[0] <= s2_c + q2x;
      s3_cand[1] <= s2_c;
      s3_cand[2] <= s2_c - q2x;
      s3_cand[3] <= s2_c - (q2x <<< 1);
      s3_q       <= s2_q;
    end
  end

  // Exactly one candidate lands in [0, q) for in-range operands.
  always_comb begin
    sel = '0;
    q3x = wide_t'({{(W-N){1'b0}}, s3_q});
    for (int i = 0; i < 4; i++) begin
      if (!s3_cand[i][W-1] && (s3_cand[i] < q3x)) sel = s3_cand[i][N-1:0];
    end
  end
endmodule
